// File: rtl/axi_lite_master.sv
// -----------------------------------------------------------------------------
// axi_lite_master
//   Bridges a single-outstanding CPU request/response port (LSU/IFU) onto an
//   AXI4-Lite master. Exactly one transaction is in flight at a time; the read
//   and write paths share one FSM. Slave errors (SLVERR/DECERR) and misaligned
//   requests come back to the requester as rsp_err.
//
//   Handshake rule on every channel (req, rsp, aw, w, b, ar, r): a transfer
//   happens on the rising clk edge where valid && ready are both 1. Once a
//   valid is raised it stays high, with its payload stable, until that edge.
//   No ready output depends combinationally on a slave valid.
//
// Ports
//   clk, reset_n            clock; asynchronous active-low reset
//   req_valid/req_ready     request handshake (req_ready=1 only in IDLE)
//   req_we/addr/wdata/wstrb request payload (addr must be 4-byte aligned)
//   rsp_valid/rsp_ready     response handshake (rsp_valid held until taken)
//   rsp_rdata/rsp_err       response payload (rdata=0 for writes and errors)
//   m_aw*/m_w*/m_b*         AXI4-Lite write address/data/response channels
//   m_ar*/m_r*              AXI4-Lite read address/data channels
//   dbg_state               current FSM state encoding
// -----------------------------------------------------------------------------
module axi_lite_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [3:0]        req_wstrb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              m_awvalid,
   input  logic              m_awready,
   output logic [ADDR_W-1:0] m_awaddr,
   output logic [2:0]        m_awprot,
   output logic              m_wvalid,
   input  logic              m_wready,
   output logic [DATA_W-1:0] m_wdata,
   output logic [3:0]        m_wstrb,
   input  logic              m_bvalid,
   output logic              m_bready,
   input  logic [1:0]        m_bresp,
   output logic              m_arvalid,
   input  logic              m_arready,
   output logic [ADDR_W-1:0] m_araddr,
   output logic [2:0]        m_arprot,
   input  logic              m_rvalid,
   output logic              m_rready,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic [1:0]        m_rresp,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_AR   = 3'd1,
      S_RD_R    = 3'd2,
      S_WR_AW_W = 3'd3,
      S_WR_B    = 3'd4,
      S_RSP     = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [3:0]        r_wstrb;
   logic              r_aw_done;
   logic              r_w_done;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;

   logic w_req_fire;
   logic w_misaligned;
   logic w_aw_fire;
   logic w_w_fire;
   logic w_r_fire;
   logic w_b_fire;

   // All bus-facing controls decode straight from registered state, so an
   // asynchronous reset drops every valid in the same instant.
   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = (r_state == S_RSP);
   assign m_arvalid = (r_state == S_RD_AR);
   assign m_rready  = (r_state == S_RD_R);
   // Each write channel goes quiet once its own handshake is done.
   assign m_awvalid = (r_state == S_WR_AW_W) && !r_aw_done;
   assign m_wvalid  = (r_state == S_WR_AW_W) && !r_w_done;
   assign m_bready  = (r_state == S_WR_B);

   assign m_araddr  = r_addr;
   assign m_awaddr  = r_addr;
   assign m_wdata   = r_wdata;
   assign m_wstrb   = r_wstrb;
   assign m_arprot  = 3'b000;
   assign m_awprot  = 3'b000;
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;
   assign dbg_state = r_state;

   assign w_req_fire   = (r_state == S_IDLE) && req_valid;
   assign w_misaligned = (req_addr[1:0] != 2'b00);
   assign w_aw_fire    = m_awvalid && m_awready;
   assign w_w_fire     = m_wvalid && m_wready;
   assign w_r_fire     = m_rready && m_rvalid;
   assign w_b_fire     = m_bready && m_bvalid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (w_misaligned) begin
                  w_state_nxt = S_RSP;
               end else if (req_we) begin
                  w_state_nxt = S_WR_AW_W;
               end else begin
                  w_state_nxt = S_RD_AR;
               end
            end
         end
         S_RD_AR: begin
            if (m_arready) w_state_nxt = S_RD_R;
         end
         S_RD_R: begin
            if (m_rvalid) w_state_nxt = S_RSP;
         end
         S_WR_AW_W: begin
            // A handshake landing on this edge counts as done already.
            if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
               w_state_nxt = S_WR_B;
            end
         end
         S_WR_B: begin
            if (m_bvalid) w_state_nxt = S_RSP;
         end
         S_RSP: begin
            if (rsp_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_req_fire) begin
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_wstrb   <= req_wstrb;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= '0;
            // A misaligned request skips the bus and answers with an error.
            r_err     <= w_misaligned;
         end
         if (w_aw_fire) r_aw_done <= 1'b1;
         if (w_w_fire)  r_w_done  <= 1'b1;
         if (w_r_fire) begin
            r_err   <= (m_rresp != 2'b00);
            r_rdata <= (m_rresp == 2'b00) ? m_rdata : '0;
         end
         if (w_b_fire) begin
            r_err   <= (m_bresp != 2'b00);
            r_rdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_master.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_master
//   Drives axi_lite_master through its request port against a behavioural
//   AXI4-Lite slave with per-channel wait-state settings. Expected responses,
//   latencies and bus traffic come from simple rules: a channel with N wait
//   states keeps its valid up for N+1 cycles, errors follow resp != OKAY, and
//   misaligned requests never reach the bus.
// -----------------------------------------------------------------------------
module tb_axi_lite_master;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_wstrb = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        m_awvalid;
   logic        m_awready = 1'b0;
   logic [31:0] m_awaddr;
   logic [2:0]  m_awprot;
   logic        m_wvalid;
   logic        m_wready = 1'b0;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_bvalid = 1'b0;
   logic        m_bready;
   logic [1:0]  m_bresp = '0;
   logic        m_arvalid;
   logic        m_arready = 1'b0;
   logic [31:0] m_araddr;
   logic [2:0]  m_arprot;
   logic        m_rvalid = 1'b0;
   logic        m_rready;
   logic [31:0] m_rdata = '0;
   logic [1:0]  m_rresp = '0;
   logic [2:0]  dbg_state;

   int n_vec = 0;
   int n_mis = 0;

   // slave configuration
   int          cfg_ar_lat = 0, cfg_r_lat = 0, cfg_aw_lat = 0, cfg_w_lat = 0, cfg_b_lat = 0;
   logic [31:0] cfg_rdata = '0;
   logic [1:0]  cfg_rresp = '0, cfg_bresp = '0;

   // slave state and monitors
   int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   bit          r_pend = 0, b_pend = 0, got_aw = 0, got_w = 0;
   bit          pw_ar = 0, pw_aw = 0, pw_w = 0;
   logic [31:0] pv_araddr, pv_awaddr;
   logic [35:0] pv_w;
   int          mon_ar_cyc = 0, mon_aw_cyc = 0, mon_w_cyc = 0, n_b = 0, n_viol = 0;
   logic [31:0] ar_q[$];
   logic [31:0] aw_q[$];
   logic [35:0] w_q[$];
   logic [31:0] exp_q[$];
   logic [35:0] exp_w_q[$];

   axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
      .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, state=%0d", dbg_state);
      n_mis++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural slave ----------------
   // Works on the falling edge: DUT outputs are stable here, so the handshakes
   // that will happen on the next rising edge are known in advance.
   always @(negedge clk) begin
      if (!reset_n) begin
         m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0;
         r_pend = 0; b_pend = 0; got_aw = 0; got_w = 0;
         pw_ar = 0; pw_aw = 0; pw_w = 0;
         ar_cnt = cfg_ar_lat; aw_cnt = cfg_aw_lat; w_cnt = cfg_w_lat;
      end else begin
         if (pw_ar && !(m_arvalid && m_araddr === pv_araddr)) n_viol++;
         if (pw_aw && !(m_awvalid && m_awaddr === pv_awaddr)) n_viol++;
         if (pw_w && !(m_wvalid && {m_wstrb, m_wdata} === pv_w)) n_viol++;
         if (m_arvalid && (m_awvalid || m_wvalid)) n_viol++;
         if ((m_arvalid && m_arprot !== 3'b000) || (m_awvalid && m_awprot !== 3'b000)) n_viol++;
         m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0;
         if (b_pend) begin
            if (b_cnt == 0) begin
               m_bvalid = 1; m_bresp = cfg_bresp;
               if (m_bready) begin b_pend = 0; n_b++; end
            end else b_cnt--;
         end
         if (r_pend) begin
            if (r_cnt == 0) begin
               m_rvalid = 1; m_rdata = cfg_rdata; m_rresp = cfg_rresp;
               if (m_rready) r_pend = 0;
            end else r_cnt--;
         end
         if (m_arvalid) begin
            mon_ar_cyc++;
            if (ar_cnt == 0) begin
               m_arready = 1; ar_q.push_back(m_araddr);
               r_pend = 1; r_cnt = cfg_r_lat; ar_cnt = cfg_ar_lat;
            end else ar_cnt--;
         end else ar_cnt = cfg_ar_lat;
         if (m_awvalid) begin
            mon_aw_cyc++;
            if (aw_cnt == 0) begin
               m_awready = 1; aw_q.push_back(m_awaddr); got_aw = 1; aw_cnt = cfg_aw_lat;
            end else aw_cnt--;
         end else aw_cnt = cfg_aw_lat;
         if (m_wvalid) begin
            mon_w_cyc++;
            if (w_cnt == 0) begin
               m_wready = 1; w_q.push_back({m_wstrb, m_wdata}); got_w = 1; w_cnt = cfg_w_lat;
            end else w_cnt--;
         end else w_cnt = cfg_w_lat;
         if (got_aw && got_w) begin
            got_aw = 0; got_w = 0; b_pend = 1; b_cnt = cfg_b_lat;
         end
         pw_ar = m_arvalid && !m_arready; pv_araddr = m_araddr;
         pw_aw = m_awvalid && !m_awready; pv_awaddr = m_awaddr;
         pw_w  = m_wvalid && !m_wready;   pv_w = {m_wstrb, m_wdata};
      end
   end

   // ---------------- reference timing ----------------
   function automatic int rd_lat(input int a, input int r);
      return a + r + 3;
   endfunction

   function automatic int wr_lat(input int aw, input int w, input int b);
      return ((aw > w) ? aw : w) + b + 3;
   endfunction

   task automatic set_lat(input int ar, input int r, input int aw, input int w, input int b);
      cfg_ar_lat = ar; cfg_r_lat = r; cfg_aw_lat = aw; cfg_w_lat = w; cfg_b_lat = b;
   endtask

   task automatic clear_mon;
      mon_ar_cyc = 0; mon_aw_cyc = 0; mon_w_cyc = 0; n_b = 0;
      ar_q.delete(); aw_q.delete(); w_q.delete(); exp_q.delete(); exp_w_q.delete();
   endtask

   // ---------------- driver ----------------
   // Issues one request, waits for the response, holds rsp_ready low for
   // 'hold' cycles (checking the response against the expected one), then
   // consumes it.
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int hold,
                         input logic [31:0] e_rdata, input logic e_err,
                         output logic [31:0] rdata, output logic err, output int lat);
      int guard;
      @(negedge clk);
      req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
      guard = 0;
      while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
      n_vec++;
      if (req_ready !== 1'b1) begin
         n_mis++; $display("FAIL req_accept: req_ready=%b, expected 1", req_ready);
      end
      @(negedge clk);
      req_valid = 0;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      n_vec++;
      if (rsp_valid !== 1'b1) begin
         n_mis++; $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, expected 1 (state %0d)", rsp_valid, lat, dbg_state);
      end
      rdata = rsp_rdata; err = rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         n_vec++;
         if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== e_rdata || rsp_err !== e_err) begin
            n_mis++;
            $display("FAIL rsp_hold: cycle %0d got valid=%b req_ready=%b rdata=%h err=%b, expected 1/0/%h/%b",
                     i, rsp_valid, req_ready, rsp_rdata, rsp_err, e_rdata, e_err);
         end
      end
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      n_vec++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_mis++; $display("FAIL rsp_release: req_ready=%b rsp_valid=%b, expected 1/0", req_ready, rsp_valid);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      reset_n = 0;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({req_ready, rsp_valid, rsp_err, m_arvalid, m_awvalid, m_wvalid, m_bready, m_rready} !== 8'b1000_0000
          || rsp_rdata !== 32'h0) begin
         n_mis++;
         $display("FAIL reset_hold: rdy/val/err/ar/aw/w/b/r=%b rdata=%h, expected 10000000 / 0",
                  {req_ready, rsp_valid, rsp_err, m_arvalid, m_awvalid, m_wvalid, m_bready, m_rready}, rsp_rdata);
      end
      #2 reset_n = 1;
      @(negedge clk);
      n_vec++;
      if ({req_ready, rsp_valid, rsp_err, m_arvalid, m_awvalid, m_wvalid, m_bready, m_rready} !== 8'b1000_0000) begin
         n_mis++;
         $display("FAIL reset_release: rdy/val/err/ar/aw/w/b/r=%b, expected 10000000",
                  {req_ready, rsp_valid, rsp_err, m_arvalid, m_awvalid, m_wvalid, m_bready, m_rready});
      end
   endtask

   task automatic test_read_basic;
      logic [31:0] d; logic e; int lat;
      set_lat(0, 0, 0, 0, 0); cfg_rdata = 32'h0000_1234; cfg_rresp = 2'b00; clear_mon();
      do_req(1'b0, 32'h0a00_0048, 32'h0, 4'h0, 0, 32'h0000_1234, 1'b0, d, e, lat);
      n_vec++;
      if (lat !== rd_lat(0, 0)) begin n_mis++; $display("FAIL rd_latency: got %0d, expected %0d", lat, rd_lat(0, 0)); end
      n_vec++;
      if (d !== 32'h0000_1234 || e !== 1'b0) begin n_mis++; $display("FAIL rd_data: got %h err=%b, expected 00001234 err=0", d, e); end
      n_vec++;
      if (mon_ar_cyc !== 1 || ar_q.size() != 1 || ar_q[0] !== 32'h0a00_0048 || aw_q.size() != 0) begin
         n_mis++; $display("FAIL rd_bus: arvalid cycles=%0d ar count=%0d aw count=%0d, expected 1/1/0", mon_ar_cyc, ar_q.size(), aw_q.size());
      end
   endtask

   task automatic test_write_aw_early;
      logic [31:0] d; logic e; int lat;
      set_lat(0, 0, 0, 2, 0); cfg_bresp = 2'b00; clear_mon();
      do_req(1'b1, 32'h8000_0010, 32'hdead_beef, 4'hf, 0, 32'h0, 1'b0, d, e, lat);
      n_vec++;
      if (lat !== wr_lat(0, 2, 0)) begin n_mis++; $display("FAIL wr_latency: got %0d, expected %0d", lat, wr_lat(0, 2, 0)); end
      n_vec++;
      if (mon_aw_cyc !== 1 || mon_w_cyc !== 3) begin
         n_mis++; $display("FAIL wr_valid_cycles: awvalid=%0d wvalid=%0d, expected 1/3", mon_aw_cyc, mon_w_cyc);
      end
      n_vec++;
      if (aw_q.size() != 1 || w_q.size() != 1 || aw_q[0] !== 32'h8000_0010 || w_q[0] !== {4'hf, 32'hdead_beef} || n_b !== 1) begin
         n_mis++; $display("FAIL wr_bus: aw=%0d w=%0d b=%0d, expected one of each with matching payload", aw_q.size(), w_q.size(), n_b);
      end
      n_vec++;
      if (d !== 32'h0 || e !== 1'b0) begin n_mis++; $display("FAIL wr_rsp: got %h err=%b, expected 0 err=0", d, e); end
   endtask

   task automatic test_errors;
      logic [31:0] d; logic e; int lat;
      set_lat(0, 1, 1, 0, 1); cfg_bresp = 2'b10; clear_mon();
      do_req(1'b1, 32'h0a00_0048, 32'h0000_0001, 4'h1, 0, 32'h0, 1'b1, d, e, lat);
      n_vec++;
      if (e !== 1'b1 || d !== 32'h0) begin n_mis++; $display("FAIL wr_slverr: got %h err=%b, expected 0 err=1", d, e); end
      cfg_bresp = 2'b00; cfg_rresp = 2'b10; cfg_rdata = 32'hcafe_f00d;
      do_req(1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, 32'h0, 1'b1, d, e, lat);
      n_vec++;
      if (e !== 1'b1 || d !== 32'h0) begin n_mis++; $display("FAIL rd_slverr: got %h err=%b, expected 0 err=1", d, e); end
      cfg_rresp = 2'b00;
   endtask

   task automatic test_misaligned;
      logic [31:0] d; logic e; int lat;
      for (int k = 0; k < 2; k++) begin
         set_lat(0, 0, 0, 0, 0); clear_mon();
         do_req(k[0], 32'h8000_0002, 32'h1111_2222, 4'hf, 0, 32'h0, 1'b1, d, e, lat);
         n_vec++;
         if (lat !== 1 || e !== 1'b1 || d !== 32'h0) begin
            n_mis++; $display("FAIL misaligned_rsp: we=%0d lat=%0d err=%b rdata=%h, expected 1/1/0", k, lat, e, d);
         end
         n_vec++;
         if (mon_ar_cyc !== 0 || mon_aw_cyc !== 0 || mon_w_cyc !== 0) begin
            n_mis++; $display("FAIL misaligned_bus: ar=%0d aw=%0d w=%0d cycles, expected 0/0/0", mon_ar_cyc, mon_aw_cyc, mon_w_cyc);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] d; logic e; int lat;
      set_lat(1, 0, 0, 0, 0); cfg_rresp = 2'b00; cfg_rdata = 32'h5a5a_0f0f; clear_mon();
      do_req(1'b0, 32'h8000_0100, 32'h0, 4'h0, 5, 32'h5a5a_0f0f, 1'b0, d, e, lat);
      n_vec++;
      if (d !== 32'h5a5a_0f0f || e !== 1'b0 || lat !== rd_lat(1, 0)) begin
         n_mis++; $display("FAIL bp_rsp: got %h err=%b lat=%0d, expected 5a5a0f0f err=0 lat=%0d", d, e, lat, rd_lat(1, 0));
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d; logic e; int lat;
      set_lat(0, 20, 0, 0, 0); clear_mon();
      @(negedge clk);
      req_valid = 1; req_we = 0; req_addr = 32'h8000_0200;
      @(negedge clk);
      req_valid = 0;
      @(negedge clk);
      n_vec++;
      if (m_rready !== 1'b1 || m_arvalid !== 1'b0) begin
         n_mis++; $display("FAIL mid_setup: rready=%b arvalid=%b, expected 1/0", m_rready, m_arvalid);
      end
      #2 reset_n = 0;
      #1;
      n_vec++;
      if ({m_arvalid, m_rready, rsp_valid, req_ready} !== 4'b0001) begin
         n_mis++; $display("FAIL mid_reset_now: ar/r/rsp/req_ready=%b, expected 0001", {m_arvalid, m_rready, rsp_valid, req_ready});
      end
      @(negedge clk);
      #2 reset_n = 1;
      @(negedge clk);
      n_vec++;
      if ({m_arvalid, m_rready, rsp_valid, req_ready} !== 4'b0001) begin
         n_mis++; $display("FAIL mid_reset_release: ar/r/rsp/req_ready=%b, expected 0001", {m_arvalid, m_rready, rsp_valid, req_ready});
      end
      set_lat(0, 0, 0, 0, 0); cfg_rdata = 32'h0bad_f00d; cfg_rresp = 2'b00;
      do_req(1'b0, 32'h8000_0204, 32'h0, 4'h0, 0, 32'h0bad_f00d, 1'b0, d, e, lat);
      n_vec++;
      if (d !== 32'h0bad_f00d || e !== 1'b0) begin n_mis++; $display("FAIL mid_recover: got %h err=%b, expected 0badf00d err=0", d, e); end
   endtask

   task automatic test_random;
      logic [31:0] d, addr, wdata, e_rdata;
      logic [3:0]  wstrb;
      logic        e, we, e_err, ok;
      int          lat, e_lat, hold;
      for (int t = 0; t < 40; t++) begin
         we = 1'($urandom_range(0, 1));
         addr = $urandom & 32'hffff_fffc;
         if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
         wdata = $urandom; wstrb = 4'($urandom_range(0, 15)); hold = $urandom_range(0, 2);
         set_lat($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         cfg_rdata = $urandom;
         cfg_rresp = ($urandom_range(0, 2) != 0) ? 2'b00 : 2'($urandom_range(1, 3));
         cfg_bresp = ($urandom_range(0, 2) != 0) ? 2'b00 : 2'($urandom_range(1, 3));
         clear_mon();
         if (addr[1:0] != 2'b00) begin
            e_err = 1'b1; e_rdata = 32'h0; e_lat = 1;
         end else if (!we) begin
            e_err = (cfg_rresp != 2'b00); e_rdata = e_err ? 32'h0 : cfg_rdata;
            e_lat = rd_lat(cfg_ar_lat, cfg_r_lat); exp_q.push_back(addr);
         end else begin
            e_err = (cfg_bresp != 2'b00); e_rdata = 32'h0;
            e_lat = wr_lat(cfg_aw_lat, cfg_w_lat, cfg_b_lat);
            exp_q.push_back(addr); exp_w_q.push_back({wstrb, wdata});
         end
         do_req(we, addr, wdata, wstrb, hold, e_rdata, e_err, d, e, lat);
         n_vec++;
         if (d !== e_rdata || e !== e_err || lat !== e_lat) begin
            n_mis++;
            $display("FAIL rnd_rsp: #%0d we=%b addr=%h got rdata=%h err=%b lat=%0d, expected %h/%b/%0d",
                     t, we, addr, d, e, lat, e_rdata, e_err, e_lat);
         end
         if (addr[1:0] != 2'b00) ok = (ar_q.size() == 0 && aw_q.size() == 0 && w_q.size() == 0);
         else if (!we) ok = (ar_q.size() == 1 && aw_q.size() == 0 && w_q.size() == 0 && ar_q[0] === exp_q[0]);
         else ok = (aw_q.size() == 1 && w_q.size() == 1 && ar_q.size() == 0 &&
                    aw_q[0] === exp_q[0] && w_q[0] === exp_w_q[0] && n_b == 1);
         n_vec++;
         if (!ok) begin
            n_mis++;
            $display("FAIL rnd_bus: #%0d we=%b addr=%h got ar=%0d aw=%0d w=%0d b=%0d transfers, expected payload-matched traffic",
                     t, we, addr, ar_q.size(), aw_q.size(), w_q.size(), n_b);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_read_basic();
      test_write_aw_early();
      test_errors();
      test_misaligned();
      test_backpressure();
      test_reset_mid();
      test_random();
      n_vec++;
      if (n_viol !== 0) begin
         n_mis++; $display("FAIL protocol: %0d valid-stability/exclusivity/prot violations, expected 0", n_viol);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
